dmem_responder: RTL and testbench

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/dmem_responder.sv | 177 +++++++++++++++++
 tb/tb_dmem_responder.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// dmem_responder: single-outstanding data-memory responder for a CPU load/store
// port, backed by a word-addressed storage array with byte-lane write enables.
//
// Ports
//   clk        : clock, all state updates on the rising edge
//   rst        : asynchronous, active-low reset
//   req_valid  : CPU presents a load/store request
//   req_ready  : responder can accept a request (IDLE only)
//   req_we     : 1 = store, 0 = load
//   req_addr   : byte address
//   req_wdata  : store data
//   req_wstrb  : byte-lane enables, bit i enables lane i
//   rsp_valid  : response presented
//   rsp_ready  : CPU accepts the response
//   rsp_rdata  : load data (0 for stores, errors and whenever rsp_valid=0)
//   rsp_err    : request failed (out of range, or misaligned when trapping)
//
// Build option
//   DMEM_MISALIGN_TRAP_EN : when defined, addr[1:0]!=0 produces an error
//                           response; otherwise the low address bits are ignored.
module dmem_responder #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int DEPTH_WORDS   = 256,
  parameter int LATENCY       = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_we,
  input  logic [ADDRESS_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0]    req_wdata,
  input  logic [3:0]               req_wstrb,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [DATA_WIDTH-1:0]    rsp_rdata,
  output logic                     rsp_err
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t                    state_q, state_d;
  logic [3:0]                cnt_q;
  logic                      alive_q;
  logic                      lat_we_q;
  logic [ADDRESS_WIDTH-1:0]  lat_addr_q;
  logic [DATA_WIDTH-1:0]     lat_wdata_q;
  logic [3:0]                lat_wstrb_q;
  logic [DATA_WIDTH-1:0]     rdata_q;
  logic                      err_q;

  logic                      accept;
  logic                      fire;

  logic                      op_we;
  logic [ADDRESS_WIDTH-1:0]  op_addr;
  logic [DATA_WIDTH-1:0]     op_wdata;
  logic [3:0]                op_wstrb;
  logic [IDX_W-1:0]          idx;
  logic                      in_range;
  logic                      misal;
  logic                      trap_en;
  logic                      ok;

  logic [DATA_WIDTH-1:0]     mem [DEPTH_WORDS];

`ifdef DMEM_MISALIGN_TRAP_EN
  assign trap_en = 1'b1;
`else
  assign trap_en = 1'b0;
`endif

  // The storage operation happens on the edge that enters RESP. With
  // LATENCY=1 that is the accept edge itself, so the live request fields are
  // used while in IDLE; otherwise the latched copy is used.
  assign op_we    = (state_q == IDLE) ? req_we    : lat_we_q;
  assign op_addr  = (state_q == IDLE) ? req_addr  : lat_addr_q;
  assign op_wdata = (state_q == IDLE) ? req_wdata : lat_wdata_q;
  assign op_wstrb = (state_q == IDLE) ? req_wstrb : lat_wstrb_q;

  assign idx      = op_addr[IDX_W+1:2];
  assign in_range = ((op_addr >> (IDX_W + 2)) == '0);
  assign misal    = trap_en && (op_addr[1:0] != 2'b00);
  assign ok       = in_range && !misal;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    accept    = 1'b0;
    fire      = 1'b0;
    state_d   = state_q;
    // alive_q holds ready low until the first edge after reset release.
    req_ready = alive_q && (state_q == IDLE);
    rsp_valid = (state_q == RESP);
    accept    = req_valid && req_ready;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (LATENCY == 1) begin
            state_d = RESP;
            fire    = 1'b1;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (cnt_q == 4'd1) begin
          state_d = RESP;
          fire    = 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      alive_q     <= 1'b0;
      cnt_q       <= 4'd0;
      lat_we_q    <= 1'b0;
      lat_addr_q  <= '0;
      lat_wdata_q <= '0;
      lat_wstrb_q <= 4'd0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      alive_q <= 1'b1;
      if (accept) begin
        lat_we_q    <= req_we;
        lat_addr_q  <= req_addr;
        lat_wdata_q <= req_wdata;
        lat_wstrb_q <= req_wstrb;
        cnt_q       <= (LATENCY > 1) ? 4'(LATENCY - 1) : 4'd0;
      end else if (state_q == WAIT) begin
        cnt_q <= cnt_q - 4'd1;
      end
      // Response fields are captured on entry to RESP and zeroed on the
      // handshake so they read 0 whenever rsp_valid is low.
      if (fire) begin
        err_q   <= !ok;
        rdata_q <= (ok && !op_we) ? mem[idx] : '0;
      end else if ((state_q == RESP) && rsp_ready) begin
        err_q   <= 1'b0;
        rdata_q <= '0;
      end
    end
  end

  // Storage has no reset; a reset forces IDLE, which suppresses fire.
  always_ff @(posedge clk) begin
    if (fire && ok && op_we) begin
      for (int b = 0; b < 4; b++) begin
        if (op_wstrb[b]) mem[idx][8*b +: 8] <= op_wdata[8*b +: 8];
      end
    end
  end

  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder with default parameters (LATENCY=2,
// DEPTH_WORDS=256).
module tb_dmem_responder;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_wstrb;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int checks   = 0;
  int failures = 0;

  dmem_responder #(
    .ADDRESS_WIDTH(32),
    .DATA_WIDTH   (32),
    .DEPTH_WORDS  (256),
    .LATENCY      (2)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_we   (req_we),
    .req_addr (req_addr),
    .req_wdata(req_wdata),
    .req_wstrb(req_wstrb),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata),
    .rsp_err  (rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  // Full transaction, called at a negedge; checks 2-cycle latency and
  // the response contents, then completes the handshake.
  task automatic xact(input string tag, input logic we, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [3:0] wstrb,
                      input logic [31:0] exp_rdata, input logic exp_err);
    int n;
    n = 0;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    req_wstrb = wstrb;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, " ready"}, {31'd0, req_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    chk({tag, " valid_c1"}, {31'd0, rsp_valid}, 32'd0);
    @(negedge clk);
    chk({tag, " valid_c2"}, {31'd0, rsp_valid}, 32'd1);
    chk({tag, " rdata"}, rsp_rdata, exp_rdata);
    chk({tag, " err"}, {31'd0, rsp_err}, {31'd0, exp_err});
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk({tag, " valid_done"}, {31'd0, rsp_valid}, 32'd0);
    chk({tag, " rdata_idle"}, rsp_rdata, 32'd0);
  endtask

  initial begin
    logic [31:0] held;
    rst       = 1'b0;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    req_wstrb = 4'd0;
    rsp_ready = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst ready", {31'd0, req_ready}, 32'd0);
    chk("rst valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst rdata", rsp_rdata, 32'd0);
    chk("rst err", {31'd0, rsp_err}, 32'd0);
    rst = 1'b1;
    #1;
    chk("release ready", {31'd0, req_ready}, 32'd0);
    @(negedge clk);
    chk("ready after edge", {31'd0, req_ready}, 32'd1);

    // Full-word store then load
    xact("st10", 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 32'h0, 1'b0);
    xact("ld10", 1'b0, 32'h10, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0);

    // Single-lane store
    xact("st10b", 1'b1, 32'h10, 32'h00000055, 4'h1, 32'h0, 1'b0);
    xact("ld10b", 1'b0, 32'h10, 32'h0, 4'h0, 32'hDEADBE55, 1'b0);

    // Zero-strobe store leaves the word untouched
    xact("st10z", 1'b1, 32'h10, 32'hFFFFFFFF, 4'h0, 32'h0, 1'b0);
    xact("ld10z", 1'b0, 32'h10, 32'h0, 4'h0, 32'hDEADBE55, 1'b0);

    // Top word, bottom word, then out-of-range accesses
    xact("st3fc", 1'b1, 32'h3FC, 32'hA5A55A5A, 4'hF, 32'h0, 1'b0);
    xact("st000", 1'b1, 32'h0, 32'h11112222, 4'hF, 32'h0, 1'b0);
    xact("ld400", 1'b0, 32'h400, 32'h0, 4'h0, 32'h0, 1'b1);
    xact("st400", 1'b1, 32'h400, 32'h99999999, 4'hF, 32'h0, 1'b1);
    xact("ld3fc", 1'b0, 32'h3FC, 32'h0, 4'h0, 32'hA5A55A5A, 1'b0);
    xact("ld000", 1'b0, 32'h0, 32'h0, 4'h0, 32'h11112222, 1'b0);

    // Non-contiguous lanes 1 and 3
    xact("st3fcA", 1'b1, 32'h3FC, 32'h11223344, 4'hA, 32'h0, 1'b0);
    xact("ld3fcA", 1'b0, 32'h3FC, 32'h0, 4'h0, 32'h11A5335A, 1'b0);

    // Misaligned load
`ifdef DMEM_MISALIGN_TRAP_EN
    xact("ld11", 1'b0, 32'h11, 32'h0, 4'h0, 32'h0, 1'b1);
`else
    xact("ld11", 1'b0, 32'h11, 32'h0, 4'h0, 32'hDEADBE55, 1'b0);
`endif

    // Backpressure with a second request already pending
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = 32'h10;
    req_wstrb = 4'h0;
    @(posedge clk);
    @(negedge clk);
    req_addr = 32'h3FC;
    @(negedge clk);
    chk("bp valid0", {31'd0, rsp_valid}, 32'd1);
    chk("bp rdata0", rsp_rdata, 32'hDEADBE55);
    held = rsp_rdata;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp valid", {31'd0, rsp_valid}, 32'd1);
      chk("bp rdata", rsp_rdata, held);
      chk("bp ready", {31'd0, req_ready}, 32'd0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("bp hs valid", {31'd0, rsp_valid}, 32'd0);
    chk("bp hs ready", {31'd0, req_ready}, 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
    chk("bp next accepted", {31'd0, req_ready}, 32'd0);
    chk("bp next c1", {31'd0, rsp_valid}, 32'd0);
    @(negedge clk);
    chk("bp next c2", {31'd0, rsp_valid}, 32'd1);
    chk("bp next rdata", rsp_rdata, 32'h11A5335A);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;

    // Reset aborts an in-flight store
    xact("st20", 1'b1, 32'h20, 32'hCAFEF00D, 4'hF, 32'h0, 1'b0);
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = 32'h20;
    req_wdata = 32'h12345678;
    req_wstrb = 4'hF;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    rst = 1'b0;
    #1;
    chk("abort valid", {31'd0, rsp_valid}, 32'd0);
    chk("abort ready", {31'd0, req_ready}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("abort no rsp", {31'd0, rsp_valid}, 32'd0);
    end
    rst = 1'b1;
    @(negedge clk);
    chk("abort post valid", {31'd0, rsp_valid}, 32'd0);
    xact("ld20", 1'b0, 32'h20, 32'h0, 4'h0, 32'hCAFEF00D, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
